apb_cdc_dst_port: RTL and testbench
===================================

# apb_cdc_dst_port

Destination-side engine of the APB asynchronous bridge, running entirely in the `b_pclk` domain. It synchronises a toggle-encoded request from the source domain and replays it as a full APB3/APB4 transfer with configurable synchroniser depth. Each completion is returned as a response toggle with read data, `PSLVERR` and a timeout indication. It generalises the previous destination block with error propagation, an access-phase watchdog, and defined handling of early requests.

## Interface
Parameters:
- `ADDR_WD`, 32, address width
- `DATA_WD`, 32, data width (multiple of 8)
- `STRB_WD`, `DATA_WD/8`, write-strobe width
- `PROT_WD`, 3, protection width
- `SYNC_STAGES`, 2, request synchroniser depth (legal ≥2)
- `TIMEOUT_CYC`, 256, max ACCESS cycles before abort; 0 disables watchdog

Ports:
- `b_pclk` in 1: clock; single clock domain.
- `b_prst_n` in 1: reset, asynchronous assert, active-low.
- `b_psel`, `b_penable`, `b_pwrite` out 1: APB control signals.
- `b_paddr` out `ADDR_WD`, `b_pwdata` out `DATA_WD`, `b_pprot` out `PROT_WD`, `b_pstrb` out `STRB_WD`: APB payload.
- `b_prdata` in `DATA_WD`, `b_pready` in 1, `b_pslverr` in 1: APB completer response.
- `a_apb_req` in 1: source request toggle (asynchronous).
- `write` in 1, `addr` in `ADDR_WD`, `wdata` in `DATA_WD`, `prot` in `PROT_WD`, `strb` in `STRB_WD`: source payload, quasi-static. The source holds it stable from its `a_apb_req` toggle until it sees `b_ready_req` toggle.
- `b_ready_req` out 1: completion toggle to the source.
- `rdata` out `DATA_WD`: last read data.
- `slverr` out 1: error status of the last transfer.
- `timeout` out 1: last transfer was aborted by the watchdog.
- `busy` out 1: FSM not IDLE.

## Operation
- **Synchroniser.** `SYNC_STAGES` flops followed by one history flop on `a_apb_req`, all reset to 0.
  - `req_edge` = XOR of the last synchroniser stage and the history flop.
  - Both bridge sides share reset; the source resets `a_apb_req` to 0.
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE → SETUP when `req_edge` or `pending` is set.
  - On that transition, latch `write/addr/wdata/prot/strb` into the `b_p*` registers and clear `pending`.
  - SETUP: `b_psel`=1, `b_penable`=0. Always → ACCESS.
  - ACCESS: `b_psel`=1, `b_penable`=1.
  - ACCESS with `b_pready`=1 → IDLE, with:
    - `slverr` <= `b_pslverr`;
    - `timeout` <= 0;
    - on a read, `rdata` <= `b_prdata`;
    - `b_ready_req` toggles.
  - ACCESS when the watchdog expires (`TIMEOUT_CYC`≠0, wait counter = `TIMEOUT_CYC`-1, `b_pready`=0) → IDLE, with:
    - `slverr`=1, `timeout`=1;
    - `rdata`=0 on a read;
    - `b_ready_req` toggles.
- **Write transfers:** `rdata` holds its previous value.
- **Wait counter:** width `$clog2(TIMEOUT_CYC+1)`. Cleared on entry to ACCESS, increments each ACCESS cycle without `b_pready`, never wraps.
- **Early requests:** a `req_edge` while not IDLE is a source protocol violation. It sets the sticky `pending` flag, which is serviced on the next return to IDLE (one extra SETUP/ACCESS). The current transfer is unaffected. A second early edge while `pending` is already set is absorbed.
- **Response precedence:** `b_pready`=1 in the same cycle as watchdog expiry is a normal completion, not a timeout.
- **Stable payload:** `b_p*` payload registers change only on IDLE→SETUP.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, `pending`=0, synchroniser cleared.
  - Reset mid-transfer drops the transfer immediately: `b_psel`/`b_penable` fall asynchronously and no response toggle is produced.
- **Request latency:** a toggle of `a_apb_req` captured at edge 1 gives `b_psel`=1 after edge `SYNC_STAGES+2`. For `SYNC_STAGES`=2 that is edge 4.
- **Transfer:** `b_penable` rises one cycle after `b_psel`.
  - Zero-wait completer: transfer ends on the edge after `b_penable` rises.
  - The response outputs and `b_ready_req` update on that same edge, and `b_psel`/`b_penable` return to 0 on it.
- **Back-to-back:** minimum 1 IDLE cycle between transfers.
- **Timeout:** abort occurs `TIMEOUT_CYC` cycles after `b_penable` rises.

## Structure
- **Package `apb_cdc_pkg`:**
  - FSM state enum `apb_dst_state_e` {IDLE, SETUP, ACCESS};
  - default width localparams shared with the source-side block.
- **Sub-module `cdc_toggle_sync`:**
  - parameter `STAGES`;
  - outputs the synchronised level and a one-cycle `edge` pulse;
  - reused by the source side for `b_ready_req`.

## Test plan
- **Zero-wait write:** `SYNC_STAGES`=2, toggle `a_apb_req` with `write`=1, `addr`=0x10, `wdata`=0xA5A5_0001, `strb`=0xF → `b_psel` at edge 4, `b_penable` at edge 5, with `b_paddr`/`b_pwdata` matching. `b_ready_req` toggles at edge 6; `slverr`=0; `rdata` unchanged.
- **Read with 3 wait states:** read of `addr`=0x20, `b_prdata`=0xDEAD_BEEF → ACCESS lasts 4 cycles; `rdata`=0xDEAD_BEEF; one `b_ready_req` toggle.
- **Slave error:** `b_pslverr`=1 with `b_pready` → `slverr`=1, `timeout`=0. The next good transfer clears `slverr`.
- **Watchdog:** `TIMEOUT_CYC`=8, `b_pready` held 0 → abort after 8 ACCESS cycles with `slverr`=1, `timeout`=1, `rdata`=0 for a read, bus idle. With `TIMEOUT_CYC`=0 the transfer waits indefinitely.
- **Early toggle:** second `a_apb_req` toggle during ACCESS → first transfer completes unchanged, then exactly one extra transfer follows; two `b_ready_req` toggles in total.
- **Reset mid-ACCESS:** assert `b_prst_n` → all outputs 0 asynchronously. After release with `a_apb_req`=0 → no spurious transfer.

Source files
------------

// File: rtl/apb_cdc_pkg.sv
// Shared types and default widths for both halves of the APB asynchronous bridge.
package apb_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_dst_state_e;

  localparam int APB_ADDR_WD = 32;
  localparam int APB_DATA_WD = 32;
  localparam int APB_PROT_WD = 3;

endpackage

// File: rtl/cdc_toggle_sync.sv
// Multi-stage synchroniser for a toggle-encoded handshake line; emits the
// synchronised level and a registered one-cycle pulse per toggle.
module cdc_toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              edge_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_q[gi] <= 1'b0;
          else         sync_q[gi] <= async_i;
        end
      end else begin : g_next
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_q[gi] <= 1'b0;
          else         sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // The pulse is registered so downstream logic never sees a decode glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      hist_q <= sync_q[STAGES-1];
      edge_q <= sync_q[STAGES-1] ^ hist_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign edge_o  = edge_q;

endmodule

// File: rtl/apb_cdc_dst_port.sv
// Destination-side engine of the APB async bridge: turns a synchronised request
// toggle into an APB transfer and answers with a response toggle plus status.
module apb_cdc_dst_port
  import apb_cdc_pkg::*;
#(
  parameter int ADDR_WD     = APB_ADDR_WD,
  parameter int DATA_WD     = APB_DATA_WD,
  parameter int STRB_WD     = DATA_WD / 8,
  parameter int PROT_WD     = APB_PROT_WD,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               b_pclk,
  input  logic               b_prst_n,
  output logic               b_psel,
  output logic               b_penable,
  output logic               b_pwrite,
  output logic [ADDR_WD-1:0] b_paddr,
  output logic [DATA_WD-1:0] b_pwdata,
  output logic [PROT_WD-1:0] b_pprot,
  output logic [STRB_WD-1:0] b_pstrb,
  input  logic [DATA_WD-1:0] b_prdata,
  input  logic               b_pready,
  input  logic               b_pslverr,
  input  logic               a_apb_req,
  input  logic               write,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [PROT_WD-1:0] prot,
  input  logic [STRB_WD-1:0] strb,
  output logic               b_ready_req,
  output logic [DATA_WD-1:0] rdata,
  output logic               slverr,
  output logic               timeout,
  output logic               busy
);

  localparam int WCNT_WD = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WCNT_WD-1:0] WCNT_LAST = WCNT_WD'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [WCNT_WD-1:0] WCNT_MAX  = {WCNT_WD{1'b1}};

  apb_dst_state_e     state_q, state_d;
  logic               pending_q, pending_d;
  logic [WCNT_WD-1:0] wcnt_q;
  logic               pwrite_q;
  logic [ADDR_WD-1:0] paddr_q;
  logic [DATA_WD-1:0] pwdata_q;
  logic [PROT_WD-1:0] pprot_q;
  logic [STRB_WD-1:0] pstrb_q;
  logic               ready_req_q;
  logic [DATA_WD-1:0] rdata_q;
  logic               slverr_q;
  logic               timeout_q;

  logic req_edge;
  logic req_level_unused;
  logic latch;
  logic done;
  logic abort;
  logic wdog_expire;

  cdc_toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i   (b_pclk),
    .rst_ni  (b_prst_n),
    .async_i (a_apb_req),
    .level_o (req_level_unused),
    .edge_o  (req_edge)
  );

  assign wdog_expire = (TIMEOUT_CYC != 0) && (wcnt_q == WCNT_LAST) && !b_pready;

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Early edges outside IDLE are remembered once; further ones are absorbed.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    latch     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_edge || pending_q) begin
          state_d   = SETUP;
          pending_d = 1'b0;
          latch     = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        if (req_edge) pending_d = 1'b1;
      end
      ACCESS: begin
        if (req_edge) pending_d = 1'b1;
        if (b_pready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wdog_expire) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      wcnt_q      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      pstrb_q     <= '0;
      ready_req_q <= 1'b0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (latch) begin
        pwrite_q <= write;
        paddr_q  <= addr;
        pwdata_q <= wdata;
        pprot_q  <= prot;
        pstrb_q  <= strb;
      end
      if (state_q == SETUP) begin
        wcnt_q <= '0;
      end else if (state_q == ACCESS && !b_pready && wcnt_q != WCNT_MAX) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (done) begin
        slverr_q    <= b_pslverr;
        timeout_q   <= 1'b0;
        ready_req_q <= ~ready_req_q;
        if (!pwrite_q) rdata_q <= b_prdata;
      end else if (abort) begin
        slverr_q    <= 1'b1;
        timeout_q   <= 1'b1;
        ready_req_q <= ~ready_req_q;
        if (!pwrite_q) rdata_q <= '0;
      end
    end
  end

  assign b_psel      = (state_q != IDLE);
  assign b_penable   = (state_q == ACCESS);
  assign b_pwrite    = pwrite_q;
  assign b_paddr     = paddr_q;
  assign b_pwdata    = pwdata_q;
  assign b_pprot     = pprot_q;
  assign b_pstrb     = pstrb_q;
  assign b_ready_req = ready_req_q;
  assign rdata       = rdata_q;
  assign slverr      = slverr_q;
  assign timeout     = timeout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apb_cdc_dst_port.sv
// Directed bench: table of single transfers with edge-accurate timing checks,
// plus early-toggle, disabled-watchdog and mid-transfer reset sequences.
module tb_apb_cdc_dst_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_psel, b_penable, b_pwrite;
  logic [31:0] b_paddr, b_pwdata, b_prdata;
  logic [2:0]  b_pprot;
  logic [3:0]  b_pstrb;
  logic        b_pready, b_pslverr;
  logic        a_apb_req = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  prot = '0;
  logic [3:0]  strb = '0;
  logic        b_ready_req, slverr, timeout, busy;
  logic [31:0] rdata;

  logic        req2 = 1'b0, pready2 = 1'b0;
  logic        w_psel, w_penable, w_pwrite, w_ready, w_slverr, w_timeout, w_busy;
  logic [31:0] w_paddr, w_pwdata, w_rdata;
  logic [2:0]  w_pprot;
  logic [3:0]  w_pstrb;

  always #5 clk = ~clk;

  apb_cdc_dst_port #(.SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut (
    .b_pclk(clk), .b_prst_n(rst_n), .b_psel(b_psel), .b_penable(b_penable),
    .b_pwrite(b_pwrite), .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot),
    .b_pstrb(b_pstrb), .b_prdata(b_prdata), .b_pready(b_pready), .b_pslverr(b_pslverr),
    .a_apb_req(a_apb_req), .write(write), .addr(addr), .wdata(wdata), .prot(prot),
    .strb(strb), .b_ready_req(b_ready_req), .rdata(rdata), .slverr(slverr),
    .timeout(timeout), .busy(busy)
  );

  apb_cdc_dst_port #(.SYNC_STAGES(2), .TIMEOUT_CYC(0)) dut_nw (
    .b_pclk(clk), .b_prst_n(rst_n), .b_psel(w_psel), .b_penable(w_penable),
    .b_pwrite(w_pwrite), .b_paddr(w_paddr), .b_pwdata(w_pwdata), .b_pprot(w_pprot),
    .b_pstrb(w_pstrb), .b_prdata(b_prdata), .b_pready(pready2), .b_pslverr(b_pslverr),
    .a_apb_req(req2), .write(write), .addr(addr), .wdata(wdata), .prot(prot),
    .strb(strb), .b_ready_req(w_ready), .rdata(w_rdata), .slverr(w_slverr),
    .timeout(w_timeout), .busy(w_busy)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          nwait;
    logic [31:0] prdata;
    logic        perr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_end;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int cfg_wait = 0;
  int acc_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Completer model: inserts cfg_wait wait states, then answers with pready.
  initial begin
    b_pready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_psel && b_penable) begin
        if (acc_cnt >= cfg_wait) b_pready = 1'b1;
        else begin
          b_pready = 1'b0;
          acc_cnt++;
        end
      end else begin
        b_pready = 1'b0;
        acc_cnt  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "bench time limit");
  end

  int          psel_e, pen_e, tog_e, tog_n, psel_rises, tog_e2;
  logic        prev_ready, prev_psel;
  logic        cap_wr, cap_err, cap_to, cap_bus;
  logic [31:0] cap_addr, cap_wdata, cap_rdata, cap_addr2, cap_paddr_end;
  logic [3:0]  cap_strb;
  logic [2:0]  cap_prot;

  initial begin
    //        wr    addr        wdata          strb  prot nwait prdata        perr exp_rdata     err   to    end
    vecs[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0, 0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 6};
    vecs[1] = '{1'b0, 32'h20, 32'h0,         4'h0, 3'd2, 3,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 9};
    vecs[2] = '{1'b1, 32'h24, 32'h1234_5678, 4'h3, 3'd1, 1,  32'h5555_5555, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 7};
    vecs[3] = '{1'b0, 32'h28, 32'h0,         4'h0, 3'd0, 0,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 6};
    vecs[4] = '{1'b0, 32'h30, 32'h0,         4'h0, 3'd0, 99, 32'h7777_7777, 1'b0, 32'h0,         1'b1, 1'b1, 13};
    vecs[5] = '{1'b1, 32'h34, 32'hCAFE_0005, 4'hC, 3'd4, 7,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 13};
    vecs[6] = '{1'b1, 32'h38, 32'hCAFE_0006, 4'h1, 3'd7, 8,  32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 13};

    b_prdata = '0;
    b_pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_psel", b_psel, 0);
    check("rst_penable", b_penable, 0);
    check("rst_ready_req", b_ready_req, 0);
    check("rst_rdata", rdata, 0);
    check("rst_slverr", slverr, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_paddr", b_paddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    prev_ready = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cfg_wait  = vecs[i].nwait;
      b_prdata  = vecs[i].prdata;
      b_pslverr = vecs[i].perr;
      @(negedge clk);
      write = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      strb = vecs[i].strb; prot = vecs[i].prot;
      a_apb_req = ~a_apb_req;
      psel_e = 0; pen_e = 0; tog_e = 0; tog_n = 0;
      for (int n = 1; n <= 24; n++) begin
        @(posedge clk); #2;
        if (b_psel && psel_e == 0) begin
          psel_e = n; cap_addr = b_paddr; cap_wdata = b_pwdata; cap_wr = b_pwrite;
          cap_strb = b_pstrb; cap_prot = b_pprot;
        end
        if (b_penable && pen_e == 0) pen_e = n;
        if (b_ready_req !== prev_ready) begin
          tog_n++;
          prev_ready = b_ready_req;
          if (tog_e == 0) begin
            tog_e = n; cap_rdata = rdata; cap_err = slverr; cap_to = timeout;
            cap_bus = b_psel | b_penable | busy;
          end
        end
      end
      $display("txn %0d wr=%0d addr=0x%08h psel@%0d penable@%0d resp@%0d rdata=0x%08h slverr=%0d timeout=%0d",
               i, vecs[i].wr, vecs[i].addr, psel_e, pen_e, tog_e, cap_rdata, cap_err, cap_to);
      check($sformatf("v%0d_psel_edge", i), psel_e, 4);
      check($sformatf("v%0d_penable_edge", i), pen_e, 5);
      check($sformatf("v%0d_paddr", i), cap_addr, vecs[i].addr);
      check($sformatf("v%0d_pwdata", i), cap_wdata, vecs[i].wdata);
      check($sformatf("v%0d_pwrite", i), cap_wr, vecs[i].wr);
      check($sformatf("v%0d_pstrb", i), cap_strb, vecs[i].strb);
      check($sformatf("v%0d_pprot", i), cap_prot, vecs[i].prot);
      check($sformatf("v%0d_resp_edge", i), tog_e, vecs[i].exp_end);
      check($sformatf("v%0d_resp_count", i), tog_n, 1);
      check($sformatf("v%0d_rdata", i), cap_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_slverr", i), cap_err, vecs[i].exp_err);
      check($sformatf("v%0d_timeout", i), cap_to, vecs[i].exp_to);
      check($sformatf("v%0d_bus_idle", i), cap_bus, 0);
    end

    // Early toggles during ACCESS: one extra transfer, second early edge absorbed.
    cfg_wait = 6; b_pslverr = 1'b0; b_prdata = 32'h0;
    @(negedge clk);
    write = 1'b1; addr = 32'h40; wdata = 32'h4040_4040; strb = 4'hF; prot = 3'd0;
    a_apb_req = ~a_apb_req;
    psel_rises = 0; prev_psel = 1'b0; tog_e = 0; tog_e2 = 0; tog_n = 0;
    cap_addr2 = '0; cap_paddr_end = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #2;
      if (b_psel && !prev_psel) begin
        psel_rises++;
        if (psel_rises == 2) cap_addr2 = b_paddr;
      end
      prev_psel = b_psel;
      if (b_ready_req !== prev_ready) begin
        tog_n++;
        prev_ready = b_ready_req;
        if (tog_e == 0) begin
          tog_e = n; cap_paddr_end = b_paddr;
        end else if (tog_e2 == 0) tog_e2 = n;
      end
      if (n == 5) begin
        addr = 32'h44;
        a_apb_req = ~a_apb_req;
      end
      if (n == 7) a_apb_req = ~a_apb_req;
    end
    $display("early-toggle seq: psel rises=%0d resp toggles=%0d first@%0d second@%0d", psel_rises, tog_n, tog_e, tog_e2);
    check("early_psel_rises", psel_rises, 2);
    check("early_resp_count", tog_n, 2);
    check("early_first_end", tog_e, 12);
    check("early_first_paddr", cap_paddr_end, 32'h40);
    check("early_second_paddr", cap_addr2, 32'h44);
    check("early_second_end", tog_e2, 21);

    // Watchdog disabled: transfer waits until the completer answers.
    @(negedge clk);
    req2 = ~req2;
    repeat (30) @(posedge clk);
    #2;
    $display("no-watchdog seq: after 30 edges penable=%0d ready_req=%0d", w_penable, w_ready);
    check("nw_still_access", w_penable, 1);
    check("nw_no_resp", w_ready, 0);
    check("nw_no_timeout", w_timeout, 0);
    @(negedge clk);
    pready2 = 1'b1;
    @(posedge clk); #2;
    check("nw_resp", w_ready, 1);
    check("nw_psel_drop", w_psel, 0);
    @(negedge clk);
    pready2 = 1'b0;

    // Reset in the middle of ACCESS.
    cfg_wait = 99;
    @(negedge clk);
    addr = 32'h50;
    a_apb_req = ~a_apb_req;
    repeat (7) @(posedge clk);
    #2;
    check("mid_in_access", b_penable, 1);
    #1;
    rst_n = 1'b0;
    a_apb_req = 1'b0;
    req2 = 1'b0;
    #1;
    $display("reset seq: during reset psel=%0d penable=%0d ready_req=%0d busy=%0d", b_psel, b_penable, b_ready_req, busy);
    check("mid_rst_psel", b_psel, 0);
    check("mid_rst_penable", b_penable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready_req", b_ready_req, 0);
    check("mid_rst_slverr", slverr, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_paddr", b_paddr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    psel_rises = 0; tog_n = 0; prev_ready = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #2;
      if (b_psel) psel_rises++;
      if (b_ready_req !== prev_ready) begin
        tog_n++;
        prev_ready = b_ready_req;
      end
    end
    check("post_rst_no_psel", psel_rises, 0);
    check("post_rst_no_resp", tog_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
